// File: rtl/btn_pkg.sv
// ============================================================================
// Package : btn_pkg
// Purpose : Shared types and default timing constants for the push-button
//           conditioner (FSM state encoding, default cycle counts at 27 MHz).
// Contents: btn_state_t, CLK_HZ, DEBOUNCE_CYCLES_DEF, LONG_CYCLES_DEF,
//           REPEAT_CYCLES_DEF
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    PRESSED    = 3'd2,
    HELD       = 3'd3,
    RELEASE_DB = 3'd4
  } btn_state_t;

  localparam int CLK_HZ              = 27000000;
  localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 50;  // 20 ms
  localparam int LONG_CYCLES_DEF     = CLK_HZ;       // 1 s
  localparam int REPEAT_CYCLES_DEF   = CLK_HZ / 10;  // 100 ms

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module  : sync_2ff
// Purpose : Two-flop synchroniser for a single asynchronous input pin. Both
//           flops reset to RESET_VAL so the pin reads as its idle level
//           straight out of reset.
// Ports   : clk  - system clock
//           rst  - synchronous, active-low reset
//           d    - asynchronous input
//           q    - synchronised output (two clk cycles of latency)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module  : button_conditioner
// Purpose : Synchronises and debounces one raw push-button, producing a clean
//           pressed level plus one-cycle press, release, long-press and
//           auto-repeat events. All outputs are registered.
// Ports   : clk       - system clock
//           rst       - synchronous, active-low reset
//           btn_i     - raw asynchronous button pin
//           level_o   - debounced pressed level, active-high
//           press_o   - one-cycle pulse on accepted press
//           release_o - one-cycle pulse on accepted release
//           long_o    - one-cycle pulse when hold reaches LONG_CYCLES
//           repeat_o  - one-cycle pulse every REPEAT_CYCLES after long_o
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
  parameter bit ACTIVE_LOW_IN   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;
  localparam int REP_W  = $clog2((REPEAT_CYCLES > 0) ? REPEAT_CYCLES : 1) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  =
    REP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam bit REPEAT_EN = (REPEAT_CYCLES > 0);

  // Synchroniser idles at the released pin level.
  localparam logic SYNC_RESET = ACTIVE_LOW_IN ? 1'b1 : 1'b0;

  logic sync_q;
  logic pressed;

  btn_state_t        state, state_next;
  logic [DB_W-1:0]   db_cnt, db_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [REP_W-1:0]  rep_cnt, rep_next;
  logic              held, held_next;  // RELEASE_DB came from HELD

  logic level_next, press_next, release_next, long_next, repeat_next;

  sync_2ff #(
    .RESET_VAL(SYNC_RESET)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_i),
    .q  (sync_q)
  );

  assign pressed = ACTIVE_LOW_IN ? ~sync_q : sync_q;

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      db_cnt    <= '0;
      hold_cnt  <= '0;
      rep_cnt   <= '0;
      held      <= 1'b0;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      long_o    <= 1'b0;
      repeat_o  <= 1'b0;
    end else begin
      state     <= state_next;
      db_cnt    <= db_next;
      hold_cnt  <= hold_next;
      rep_cnt   <= rep_next;
      held      <= held_next;
      level_o   <= level_next;
      press_o   <= press_next;
      release_o <= release_next;
      long_o    <= long_next;
      repeat_o  <= repeat_next;
    end
  end

  // Next-state and counter update. hold_cnt/rep_cnt are left untouched while
  // a release is being debounced so a short glitch only pauses the timing.
  always_comb begin
    state_next = state;
    db_next    = db_cnt;
    hold_next  = hold_cnt;
    rep_next   = rep_cnt;
    held_next  = held;
    case (state)
      IDLE: begin
        held_next = 1'b0;
        if (pressed) begin
          state_next = PRESS_DB;
          db_next    = '0;
        end
      end
      PRESS_DB: begin
        if (!pressed) begin
          state_next = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_next = PRESSED;
          hold_next  = '0;
          held_next  = 1'b0;
        end else begin
          db_next = db_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_next = RELEASE_DB;
          db_next    = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = HELD;
          rep_next   = '0;
          held_next  = 1'b1;
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!pressed) begin
          state_next = RELEASE_DB;
          db_next    = '0;
        end else if (REPEAT_EN && (rep_cnt == REP_LAST)) begin
          rep_next = '0;
        end else if (REPEAT_EN) begin
          rep_next = rep_cnt + 1'b1;
        end
      end
      RELEASE_DB: begin
        if (pressed) begin
          state_next = held ? HELD : PRESSED;
        end else if (db_cnt == DB_LAST) begin
          state_next = IDLE;
          held_next  = 1'b0;
        end else begin
          db_next = db_cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        db_next    = '0;
        hold_next  = '0;
        rep_next   = '0;
        held_next  = 1'b0;
      end
    endcase
  end

  // Output decode from the transition being taken; registered above.
  always_comb begin
    level_next   = (state_next == PRESSED) || (state_next == HELD) ||
                   (state_next == RELEASE_DB);
    press_next   = (state == PRESS_DB)   && (state_next == PRESSED);
    release_next = (state == RELEASE_DB) && (state_next == IDLE);
    long_next    = (state == PRESSED)    && (state_next == HELD);
    repeat_next  = REPEAT_EN && (state == HELD) && pressed &&
                   (rep_cnt == REP_LAST);
  end

endmodule

`default_nettype wire
